// File: rtl/idct8_chen_ts.sv
// 8-point 1-D inverse DCT, Chen factorisation, time-shared over NUM_MUL LUT multipliers.
// One row of coefficients in, one row of Q(FRAC) samples out, valid/ready on both sides.
module idct8_chen_ts #(
    parameter int IN_W    = 32,
    parameter int FRAC    = 15,
    parameter int CONST_W = 16,
    parameter int NUM_MUL = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in0,
    input  logic signed [IN_W-1:0] in1,
    input  logic signed [IN_W-1:0] in2,
    input  logic signed [IN_W-1:0] in3,
    input  logic signed [IN_W-1:0] in4,
    input  logic signed [IN_W-1:0] in5,
    input  logic signed [IN_W-1:0] in6,
    input  logic signed [IN_W-1:0] in7,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [IN_W-1:0] out0,
    output logic signed [IN_W-1:0] out1,
    output logic signed [IN_W-1:0] out2,
    output logic signed [IN_W-1:0] out3,
    output logic signed [IN_W-1:0] out4,
    output logic signed [IN_W-1:0] out5,
    output logic signed [IN_W-1:0] out6,
    output logic signed [IN_W-1:0] out7
);

    localparam logic signed [CONST_W-1:0] H1 = CONST_W'(16069);
    localparam logic signed [CONST_W-1:0] H2 = CONST_W'(15137);
    localparam logic signed [CONST_W-1:0] H3 = CONST_W'(13623);
    localparam logic signed [CONST_W-1:0] H4 = CONST_W'(11585);
    localparam logic signed [CONST_W-1:0] H5 = CONST_W'(9102);
    localparam logic signed [CONST_W-1:0] H6 = CONST_W'(6270);
    localparam logic signed [CONST_W-1:0] H7 = CONST_W'(3196);

    typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_P3, S_WAIT} state_t;

    state_t r_state, w_state_next;
    logic   w_accept;

    logic signed [IN_W-1:0]    r_x   [0:7];
    logic signed [IN_W-1:0]    r_e   [0:3];
    logic signed [IN_W-1:0]    r_o   [0:3];
    logic signed [IN_W-1:0]    r_out [0:7];
    logic signed [IN_W-1:0]    r_s04p, r_s04m;
    logic signed [IN_W-1:0]    w_in  [0:7];
    logic signed [IN_W-1:0]    w_a   [0:NUM_MUL-1];
    logic signed [CONST_W-1:0] w_c   [0:NUM_MUL-1];
    logic signed [IN_W-1:0]    w_m   [0:NUM_MUL-1];

    assign w_in[0] = in0;  assign w_in[1] = in1;  assign w_in[2] = in2;  assign w_in[3] = in3;
    assign w_in[4] = in4;  assign w_in[5] = in5;  assign w_in[6] = in6;  assign w_in[7] = in7;
    assign out0 = r_out[0];  assign out1 = r_out[1];  assign out2 = r_out[2];  assign out3 = r_out[3];
    assign out4 = r_out[4];  assign out5 = r_out[5];  assign out6 = r_out[6];  assign out7 = r_out[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_P0;
            S_P0:    w_state_next = S_P1;
            S_P1:    w_state_next = S_P2;
            S_P2:    w_state_next = S_P3;
            S_P3:    w_state_next = S_WAIT;
            S_WAIT:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_WAIT);
        w_accept  = in_ready && in_valid;
    end

    // Each lane: full-precision product, arithmetic shift, truncate to IN_W
    generate
        for (genvar gi = 0; gi < NUM_MUL; gi++) begin : g_mul
            logic signed [IN_W+CONST_W-1:0] w_full;
            assign w_full  = w_a[gi] * w_c[gi];
            assign w_m[gi] = IN_W'(w_full >>> FRAC);
        end
    endgenerate

    // Lane operand schedule: P0 even part + half of o0, P1 rest of o0/o1/half o2, P2 rest
    always_comb begin
        for (int k = 0; k < NUM_MUL; k++) begin
            w_a[k] = '0;
            w_c[k] = '0;
        end
        case (r_state)
            S_P0: begin
                w_a[0] = r_s04p; w_c[0] = H4;  w_a[1] = r_s04m; w_c[1] = H4;
                w_a[2] = r_x[2]; w_c[2] = H2;  w_a[3] = r_x[6]; w_c[3] = H6;
                w_a[4] = r_x[2]; w_c[4] = H6;  w_a[5] = r_x[6]; w_c[5] = H2;
                w_a[6] = r_x[1]; w_c[6] = H1;  w_a[7] = r_x[3]; w_c[7] = H3;
            end
            S_P1: begin
                w_a[0] = r_x[5]; w_c[0] = H5;  w_a[1] = r_x[7]; w_c[1] = H7;
                w_a[2] = r_x[1]; w_c[2] = H3;  w_a[3] = r_x[3]; w_c[3] = H7;
                w_a[4] = r_x[5]; w_c[4] = H1;  w_a[5] = r_x[7]; w_c[5] = H5;
                w_a[6] = r_x[1]; w_c[6] = H5;  w_a[7] = r_x[3]; w_c[7] = H1;
            end
            S_P2: begin
                w_a[0] = r_x[5]; w_c[0] = H7;  w_a[1] = r_x[7]; w_c[1] = H3;
                w_a[2] = r_x[1]; w_c[2] = H7;  w_a[3] = r_x[3]; w_c[3] = H5;
                w_a[4] = r_x[5]; w_c[4] = H3;  w_a[5] = r_x[7]; w_c[5] = H1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                r_x[k]   <= '0;
                r_out[k] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                r_e[k] <= '0;
                r_o[k] <= '0;
            end
            r_s04p <= '0;
            r_s04m <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    for (int k = 0; k < 8; k++) r_x[k] <= w_in[k];
                    r_s04p <= in0 + in4;
                    r_s04m <= in0 - in4;
                end
                S_P0: begin
                    r_e[0] <= w_m[0] + w_m[2] + w_m[3];
                    r_e[1] <= w_m[1] + w_m[4] - w_m[5];
                    r_e[2] <= w_m[1] - w_m[4] + w_m[5];
                    r_e[3] <= w_m[0] - w_m[2] - w_m[3];
                    r_o[0] <= w_m[6] + w_m[7];
                end
                S_P1: begin
                    r_o[0] <= r_o[0] + w_m[0] + w_m[1];
                    r_o[1] <= w_m[2] - w_m[3] - w_m[4] - w_m[5];
                    r_o[2] <= w_m[6] - w_m[7];
                end
                S_P2: begin
                    r_o[2] <= r_o[2] + w_m[0] + w_m[1];
                    r_o[3] <= w_m[2] - w_m[3] + w_m[4] - w_m[5];
                end
                S_P3: begin
                    for (int k = 0; k < 4; k++) begin
                        r_out[k]     <= r_e[k] + r_o[k];
                        r_out[7 - k] <= r_e[k] - r_o[k];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
